seg7_scan: RTL
==============

# seg7_scan

Four-digit multiplexed seven-segment display driver placed directly downstream of the cascaded decade counters. It samples a 16-bit packed BCD value (digit 0 = least significant) into a shadow register on a load strobe. It scans the four digits round-robin at a programmable rate and drives active-low segment and anode lines with registered outputs.

## Interface
- SCAN_DIV, default 50000: clocks each digit stays lit; legal range ≥ 2; prescaler width is $clog2(SCAN_DIV).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bcd  input  16  packed digits: [3:0] digit 0, [7:4] digit 1, [11:8] digit 2, [15:12] digit 3.
- load  input  1  synchronous; when high on an edge, shadow <= bcd.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- an  output  4  active-low anode select; an[i] low lights digit i.

## Operation
- Reset values: seg = 7'b1111111, an = 4'b1111, shadow = 16'h0000, prescaler = 0, idx = 3.
- Prescaler counts 0..SCAN_DIV-1 every clock and wraps to 0. `tick` is true on the edge where prescaler == SCAN_DIV-1.
- On a tick edge:
  - idx <= (idx+1) mod 4, wrapping 3 -> 0.
  - an <= all ones except bit (new idx) low.
  - seg <= decode(shadow digit at new idx).
- On non-tick edges with an != 4'b1111: seg <= decode(shadow digit at current idx). Shadow changes therefore appear without waiting for the next tick.
- Decode, active-low:
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001
  - 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000
  - codes 10-15 -> dash 0111111
  - blank -> 1111111
- load is level-sampled every edge. Back-to-back loads are legal, and the last one wins.
- Exactly one an bit is low at any time after the first tick. There is no gap cycle between digits.

## Timing
- First lit digit: digit 0, an = 4'b1110, on the SCAN_DIV-th rising edge after rst deasserts.
- Each digit is lit for exactly SCAN_DIV clocks. A full frame is 4*SCAN_DIV clocks.
- Load latency: load high on edge N writes shadow at edge N; seg reflects the new value at edge N+1.
- Load and tick on the same edge: the tick decode uses the old shadow, and seg is corrected on the following edge. This is a one-cycle stale value by design.
- rst asserted mid-scan: all outputs go to their reset values immediately (asynchronously). Scan restarts from digit 0 after SCAN_DIV clocks following release.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit i (i = 3,2,1) decodes as blank when it and every higher digit are 0. Digit 0 is never blanked, so 0000 shows "0".
  - The anode is still driven for a blanked digit, so scan timing is unchanged.
  - Nonzero invalid codes (10-15) count as nonzero and stop blanking.
- LEADING_ZERO_BLANK_EN undefined: all digits decode normally; 0007 shows "0007".

## Test plan
- Reset check, SCAN_DIV=4: assert rst mid-cycle -> seg = 1111111, an = 1111 immediately. Release rst -> an = 1110 on the 4th edge, then 1101, 1011, 0111, 1110, each held 4 clocks.
- Decode sweep: load bcd = 16'h3210, then 16'h7654, 16'hBA98 -> per-digit seg matches the table; digits with A/B show 0111111.
- Mid-digit load: while digit 0 is lit with value 5, load bcd = 16'h0009 -> seg = 0010000 one edge after the load edge, with no change in an.
- Load coincident with tick: load 16'h0001 on the tick edge entering digit 0 (old value 8) -> seg = 0000000 for one cycle, then 1111001.
- Leading-zero blanking, macro defined: load 16'h0007 -> digits 3,2,1 seg = 1111111 and digit 0 = 1111000. Load 16'h0000 -> digit 0 = 1000000. Load 16'h0A07 -> digit 3 blank, digit 2 shows dash, digit 1 = 1000000.
- Same bench, macro undefined: load 16'h0007 -> digits 3,2,1 = 1000000.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed active-low seven-segment driver with a load-strobed BCD shadow.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1 (digit 0 always shown).
module seg7_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int PW = $clog2(SCAN_DIV);
    logic [PW-1:0] pre;
    logic [1:0]    idx, idx_nxt, sel;
    logic [15:0]   shadow;
    logic [3:0]    blank, digit;
    logic [6:0]    seg_nxt;
    logic          tick;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    // On a tick the register loads the digit being entered; otherwise it refreshes the lit one.
    always_comb begin
        tick    = pre == PW'(SCAN_DIV - 1);
        idx_nxt = idx + 2'd1;
        sel     = tick ? idx_nxt : idx;
        digit   = shadow[{sel, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = shadow[15:12] == 4'd0;
        blank[2] = blank[3] && shadow[11:8] == 4'd0;
        blank[1] = blank[2] && shadow[7:4] == 4'd0;
        blank[0] = 1'b0;
`else
        blank = 4'b0000;
`endif
        seg_nxt = blank[sel] ? 7'b1111111 : decode(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            idx    <= 2'd3;
            shadow <= 16'h0000;
            seg    <= 7'b1111111;
            an     <= 4'b1111;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (load)
                shadow <= bcd;
            if (tick) begin
                idx <= idx_nxt;
                an  <= ~(4'b0001 << idx_nxt);
                seg <= seg_nxt;
            end else if (an != 4'b1111)
                seg <= seg_nxt;
        end
    end
endmodule
